// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder. On a start pulse accepted in IDLE it loads two WIDTH-bit
// operands and a carry-in. It then adds one bit pair per clock, LSB first,
// through a single full-adder slice, and registers the carry between bits.
// After WIDTH bit-cycles it updates the held result (sum, carry-out and
// signed overflow) and pulses done for one cycle.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   request pulse, sampled only in IDLE
//   a_in     in   [WIDTH] operand A
//   b_in     in   [WIDTH] operand B
//   c_in     in   carry into bit 0
//   busy     out  high while bits are being processed (SHIFT)
//   done     out  one-cycle strobe, result registers just updated
//   sum      out  [WIDTH] result of last completed addition
//   c_out    out  carry out of the MSB of the last addition
//   overflow out  signed overflow of the last addition
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             cy;
    logic             cmsb;
    logic [CW-1:0]    cnt;

    logic             bit_sum;
    logic             bit_cy;
    logic [WIDTH-1:0] s_next;

    // Full-adder slice: the one cell reused for every bit position.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign bit_sum = fa_sum(a_sr[0], b_sr[0], cy);
    assign bit_cy  = fa_carry(a_sr[0], b_sr[0], cy);
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
    assign s_next  = {bit_sum, s_sr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand load, bit-serial add, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            cy       <= 1'b0;
            cmsb     <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a_in;
                        b_sr <= b_in;
                        cy   <= c_in;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    cy   <= bit_cy;
                    cnt  <= cnt + 1'b1;
                    // The carry leaving bit WIDTH-2 is the carry into the MSB;
                    // it is needed later to form signed overflow.
                    if (cnt == CNT_PRE) begin
                        cmsb <= bit_cy;
                    end
                    if (cnt == CNT_LAST) begin
                        sum      <= s_next;
                        c_out    <= bit_cy;
                        overflow <= cmsb ^ bit_cy;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl at WIDTH=4. Expected results
// come from a plain-arithmetic model of an N-bit add with carry-in.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int n_tests;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {sum, c_out, overflow} of a + b + c, modulo 2^W.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int           total;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        total = int'(a) + int'(b) + int'(c);
        s     = total[W-1:0];
        co    = total[W];
        // Two's-complement overflow: equal-sign operands giving other-sign result.
        ov    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s, co, ov};
    endfunction

    // Present operands with start for one edge; returns at the negedge after
    // acceptance, then scrambles the inputs so late changes would show up.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        c_in  = 1'($urandom);
    endtask

    // Wait (bounded) for done. Reports cycles waited, busy cycles seen,
    // whether busy and done were ever high together, and whether the held
    // result stayed unchanged until completion.
    task automatic wait_done(output int lat, output int busy_n, output bit both_hi,
                             output bit held);
        logic [W+1:0] prev;
        prev    = {sum, c_out, overflow};
        lat     = 0;
        busy_n  = 0;
        both_hi = 1'b0;
        held    = 1'b1;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if ({sum, c_out, overflow} !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy && done) both_hi = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = 1'b0;
        #2;
        n_tests++;
        if ({busy, done, sum, c_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b required all zero",
                     {busy, done, sum, c_out, overflow});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{4'd5, 4'd15, 4'd0, 4'd8};
        logic [W-1:0] tb [4] = '{4'd3, 4'd1,  4'd0, 4'd8};
        logic         tc [4] = '{1'b0, 1'b0,  1'b1, 1'b0};
        logic [W+1:0] te [4] = '{{4'd8, 1'b0, 1'b1}, {4'd0, 1'b1, 1'b0},
                                 {4'd1, 1'b0, 1'b0}, {4'd0, 1'b1, 1'b1}};
        int lat, bn;
        bit both, held;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], tc[i]);
            wait_done(lat, bn, both, held);
            n_tests++;
            if (lat != W || bn != W || both) begin
                n_fail++;
                $display("FAIL timing_%0d: latency=%0d busy=%0d both=%0d required %0d/%0d/0",
                         i, lat, bn, both, W, W);
            end
            n_tests++;
            if ({sum, c_out, overflow} !== te[i]) begin
                n_fail++;
                $display("FAIL result_%0d: got sum=%0d c=%0d ov=%0d required %0d/%0d/%0d",
                         i, sum, c_out, overflow, te[i][W+1:2], te[i][1], te[i][0]);
            end
            n_tests++;
            if (!held) begin
                n_fail++;
                $display("FAIL hold_%0d: result changed before completion, got 0 required 1", i);
            end
            @(negedge clk);
            n_tests++;
            if ({busy, done} !== 2'b00 || {sum, c_out, overflow} !== te[i]) begin
                n_fail++;
                $display("FAIL after_done_%0d: busy/done=%b sum=%0d required 00 sum=%0d",
                         i, {busy, done}, sum, te[i][W+1:2]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [W+1:0] got;
        launch(4'd2, 4'd3, 1'b0);
        a_in  = 4'd7;
        b_in  = 4'd7;
        c_in  = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        dones = 0;
        got   = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dones++;
                got = {sum, c_out, overflow};
            end
            @(negedge clk);
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_start_dones: got %0d required 1", dones);
        end
        n_tests++;
        if (got !== model(4'd2, 4'd3, 1'b0)) begin
            n_fail++;
            $display("FAIL ignore_start_result: got %b required %b", got,
                     model(4'd2, 4'd3, 1'b0));
        end
    endtask

    task automatic test_reset_midop();
        int dones;
        int lat, bn;
        bit both, held;
        launch(4'd9, 4'd4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, sum, c_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: got %b required all zero",
                     {busy, done, sum, c_out, overflow});
        end
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midop_abandon: busy/done cycles=%0d required 0", dones);
        end
        launch(4'd6, 4'd7, 1'b0);
        wait_done(lat, bn, both, held);
        n_tests++;
        if (lat != W || {sum, c_out, overflow} !== {4'd13, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_add: latency=%0d sum=%0d c=%0d ov=%0d required %0d/13/0/1",
                     lat, sum, c_out, overflow, W);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int last;
        int dones;
        int bad_gap;
        int bad_res;
        @(negedge clk);
        a_in    = 4'd1;
        b_in    = 4'd2;
        c_in    = 1'b0;
        start   = 1'b1;
        t       = 0;
        last    = -1;
        dones   = 0;
        bad_gap = 0;
        bad_res = 0;
        while (dones < 4 && t < 80) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (last >= 0 && (t - last) != W + 2) bad_gap++;
                if ({sum, c_out, overflow} !== model(4'd1, 4'd2, 1'b0)) bad_res++;
                last = t;
                dones++;
            end
        end
        start = 1'b0;
        n_tests++;
        if (dones != 4 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL back_to_back_rate: dones=%0d bad_gaps=%0d required 4/0", dones, bad_gap);
        end
        n_tests++;
        if (bad_res != 0) begin
            n_fail++;
            $display("FAIL back_to_back_sum: wrong results=%0d required 0", bad_res);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int order [512];
        int j, tmp;
        int lat, bn;
        bit both, held;
        logic [W+1:0] exp_v;
        logic [8:0]   v;
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            v     = order[i][8:0];
            exp_v = model(v[8:5], v[4:1], v[0]);
            launch(v[8:5], v[4:1], v[0]);
            wait_done(lat, bn, both, held);
            n_tests++;
            if (lat != W || {sum, c_out, overflow} !== exp_v) begin
                n_fail++;
                $display("FAIL random a=%0d b=%0d c=%0d: got lat=%0d %b required lat=%0d %b",
                         v[8:5], v[4:1], v[0], lat, {sum, c_out, overflow}, W, exp_v);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
